// File: rtl/sync_fifo_param_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_pkg
//   Shared FIFO definitions: default geometry, read-mode encoding and the
//   pointer/count width helpers. The single-clock and dual-clock FIFOs both
//   use this package.
// -----------------------------------------------------------------------------
package sync_fifo_param_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 16;

    // Read-port behaviour of the storage array.
    typedef enum logic {
        RD_STANDARD = 1'b0,   // registered read, 1-cycle latency
        RD_FWFT     = 1'b1    // combinational head-of-queue read
    } rd_mode_e;

    // Address width for a DEPTH-entry array. The result is at least 1 bit so
    // that a DEPTH of 1 would still produce a legal vector.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of an occupancy counter that can hold 0..depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_mem
//   DEPTH x WIDTH two-port storage array: one synchronous write port and one
//   read port. The read port is either registered (RD_STANDARD, with a
//   synchronously reset output register) or combinational (RD_FWFT).
// Ports
//   clk    in   clock
//   res    in   synchronous active-high reset (read register only; the
//               storage array itself is never cleared)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable (registered mode only)
//   raddr  in   read address
//   rdata  out  read data
// -----------------------------------------------------------------------------
module sync_fifo_param_mem
    import sync_fifo_param_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned PTR_W = ptr_w(DEF_DEPTH),
    parameter rd_mode_e    MODE  = RD_STANDARD
) (
    input  logic             clk,
    input  logic             res,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    if (MODE == RD_FWFT) begin : g_comb_rd
        // The head entry is always visible, so the reset and read-enable
        // inputs have no function in this mode.
        logic unused_rd;
        assign unused_rd = &{1'b0, res, re};
        assign rdata     = mem_q[raddr];
    end else begin : g_reg_rd
        logic [WIDTH-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (res) begin
                rdata_q <= '0;
            end else if (re) begin
                rdata_q <= mem_q[raddr];
            end
        end
        assign rdata = rdata_q;
    end

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Single-clock parametrised FIFO with arbitrary depth, occupancy count,
//   programmable almost-full/almost-empty thresholds, standard or
//   first-word-fall-through read mode and sticky, clearable error flags.
// Ports
//   clk, res                synchronous active-high reset
//   wr_en, wdata            write request / data
//   rd_en                   read request (FWFT: pop head)
//   rdata, rd_valid         read data and its qualifier
//   full, empty             count == DEPTH / count == 0
//   almost_full             count >= AF_LEVEL
//   almost_empty            count <= AE_LEVEL
//   count                   current occupancy
//   overflow, underflow     sticky error flags
//   clr_err                 clears the sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = 14,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);
    localparam rd_mode_e    MODE  = (FWFT != 0) ? RD_FWFT : RD_STANDARD;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] mem_rdata;

    always_comb begin
        rd_acc = rd_en & ~empty_q;
        // A full FIFO still takes a write when the same cycle frees a slot.
        wr_acc = wr_en & (~full_q | rd_acc);

        wr_ptr_d = wr_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);

        // Flags are derived from the next count so they register in step
        // with it.
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_AF);
        ae_d    = (count_d <= CNT_AE);

        // A fresh error in the clearing cycle keeps the flag set.
        ovf_d = ovf_q;
        if (wr_en & ~wr_acc) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end
        unf_d = unf_q;
        if (rd_en & empty_q) begin
            unf_d = 1'b1;
        end else if (clr_err) begin
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    sync_fifo_param_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .MODE  (MODE)
    ) u_mem (
        .clk   (clk),
        .res   (res),
        .we    (wr_acc & ~res),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    if (MODE == RD_FWFT) begin : g_fwft
        // Head is shown only while it holds live data; stale storage is
        // masked so an empty FIFO presents zero.
        assign rdata    = empty_q ? '0 : mem_rdata;
        assign rd_valid = ~empty_q;
    end else begin : g_std
        logic rd_valid_q;
        always_ff @(posedge clk) begin
            if (res) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
            end
        end
        assign rdata    = mem_rdata;
        assign rd_valid = rd_valid_q;
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- DEPTH=16 standard-mode instance ----------------
    logic       s_res = 1'b1, s_wr = 1'b0, s_rd = 1'b0, s_clr = 1'b0;
    logic [7:0] s_wd = '0, s_rdata;
    logic       s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [4:0] s_cnt;

    sync_fifo_param u_std (
        .clk(clk), .res(s_res), .wr_en(s_wr), .wdata(s_wd), .rd_en(s_rd),
        .rdata(s_rdata), .rd_valid(s_rv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf), .clr_err(s_clr)
    );

    // ---------------- DEPTH=5 standard-mode instance ----------------
    logic       d_res = 1'b1, d_wr = 1'b0, d_rd = 1'b0, d_clr = 1'b0;
    logic [7:0] d_wd = '0, d_rdata;
    logic       d_rv, d_full, d_empty, d_af, d_ae, d_ovf, d_unf;
    logic [2:0] d_cnt;

    sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_d5 (
        .clk(clk), .res(d_res), .wr_en(d_wr), .wdata(d_wd), .rd_en(d_rd),
        .rdata(d_rdata), .rd_valid(d_rv), .full(d_full), .empty(d_empty),
        .almost_full(d_af), .almost_empty(d_ae), .count(d_cnt),
        .overflow(d_ovf), .underflow(d_unf), .clr_err(d_clr)
    );

    // ---------------- DEPTH=16 FWFT instance ----------------
    logic       f_res = 1'b1, f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
    logic [7:0] f_wd = '0, f_rdata;
    logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] f_cnt;

    sync_fifo_param #(.FWFT(1)) u_fw (
        .clk(clk), .res(f_res), .wr_en(f_wr), .wdata(f_wd), .rd_en(f_rd),
        .rdata(f_rdata), .rd_valid(f_rv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf), .clr_err(f_clr)
    );

    typedef struct {
        logic       res, wr, rd, clr;
        logic [7:0] wd;
        logic [7:0] e_rdata;
        logic       e_rv, e_full, e_empty, e_af, e_ae, e_ovf, e_unf;
        logic [4:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Flags for the DEPTH=16 / AF=14 / AE=2 instance follow from the count.
    task automatic add(input logic res, input logic wr, input logic [7:0] wd,
                       input logic rd, input logic clr, input logic [7:0] e_rdata,
                       input logic e_rv, input int e_cnt, input logic e_ovf, input logic e_unf);
        vec_t v;
        v.res = res; v.wr = wr; v.wd = wd; v.rd = rd; v.clr = clr;
        v.e_rdata = e_rdata; v.e_rv = e_rv; v.e_cnt = 5'(e_cnt);
        v.e_full  = (e_cnt == 16);
        v.e_empty = (e_cnt == 0);
        v.e_af    = (e_cnt >= 14);
        v.e_ae    = (e_cnt <= 2);
        v.e_ovf = e_ovf; v.e_unf = e_unf;
        vecs.push_back(v);
    endtask

    task automatic step_d5(input logic wr, input logic [7:0] wd, input logic rd);
        @(negedge clk);
        d_res = 1'b0; d_wr = wr; d_wd = wd; d_rd = rd;
        @(posedge clk); #1;
    endtask

    task automatic step_fw(input logic res, input logic wr, input logic [7:0] wd, input logic rd);
        @(negedge clk);
        f_res = res; f_wr = wr; f_wd = wd; f_rd = rd;
        @(posedge clk); #1;
    endtask

    initial begin
        // ---- build the standard-mode vector table ----
        add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);                 // reset
        for (int i = 0; i < 16; i++)
            add(0, 1, 8'(i), 0, 0, 8'h00, 0, i + 1, 0, 0);          // fill 0x00..0x0F
        add(0, 1, 8'hAA, 0, 0, 8'h00, 0, 16, 1, 0);                 // overflow, rejected
        add(0, 0, 8'h00, 0, 1, 8'h00, 0, 16, 0, 0);                 // clr_err
        add(0, 1, 8'h10, 1, 0, 8'h00, 1, 16, 0, 0);                 // full: rd+wr both accepted
        for (int k = 1; k < 16; k++)
            add(0, 0, 8'h00, 1, 0, 8'(k), 1, 16 - k, 0, 0);         // drain in order
        add(0, 0, 8'h00, 1, 0, 8'h10, 1, 0, 0, 0);                  // last word; 0xAA never seen
        add(0, 1, 8'h55, 1, 0, 8'h10, 0, 1, 0, 1);                  // empty rd+wr: underflow
        add(0, 0, 8'h00, 1, 0, 8'h55, 1, 0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 8'h55, 0, 0, 0, 1);                  // new error beats clear
        add(0, 0, 8'h00, 0, 1, 8'h55, 0, 0, 0, 0);                  // clear
        add(0, 1, 8'h66, 0, 0, 8'h55, 0, 1, 0, 0);
        add(0, 1, 8'h67, 0, 0, 8'h55, 0, 2, 0, 0);
        add(1, 1, 8'h68, 1, 0, 8'h00, 0, 0, 0, 0);                  // reset mid-burst wins
        add(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 1);                  // really empty

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            s_res = vecs[i].res; s_wr = vecs[i].wr; s_wd = vecs[i].wd;
            s_rd = vecs[i].rd; s_clr = vecs[i].clr;
            @(posedge clk); #1;
            chk($sformatf("v%0d.rdata", i), 32'(s_rdata), 32'(vecs[i].e_rdata));
            chk($sformatf("v%0d.rd_valid", i), 32'(s_rv), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d.count", i), 32'(s_cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d.full", i), 32'(s_full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d.empty", i), 32'(s_empty), 32'(vecs[i].e_empty));
            chk($sformatf("v%0d.almost_full", i), 32'(s_af), 32'(vecs[i].e_af));
            chk($sformatf("v%0d.almost_empty", i), 32'(s_ae), 32'(vecs[i].e_ae));
            chk($sformatf("v%0d.overflow", i), 32'(s_ovf), 32'(vecs[i].e_ovf));
            chk($sformatf("v%0d.underflow", i), 32'(s_unf), 32'(vecs[i].e_unf));
        end

        // ---- DEPTH=5: pointer wrap with order preserved ----
        chk("d5.reset_empty", 32'(d_empty), 32'd1);
        chk("d5.reset_count", 32'(d_cnt), 32'd0);
        step_d5(1, 8'h40, 0);
        chk("d5.pre1_count", 32'(d_cnt), 32'd1);
        chk("d5.pre1_ae", 32'(d_ae), 32'd1);
        step_d5(1, 8'h41, 0);
        chk("d5.pre2_count", 32'(d_cnt), 32'd2);
        chk("d5.pre2_ae", 32'(d_ae), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step_d5(1, 8'(8'h42 + i), 1);
            chk($sformatf("d5.pair%0d.rdata", i), 32'(d_rdata), 32'(8'h40 + i));
            chk($sformatf("d5.pair%0d.rd_valid", i), 32'(d_rv), 32'd1);
            chk($sformatf("d5.pair%0d.count", i), 32'(d_cnt), 32'd2);
        end
        for (int i = 0; i < 2; i++) begin
            step_d5(0, 8'h00, 1);
            chk($sformatf("d5.drain%0d.rdata", i), 32'(d_rdata), 32'(8'h4C + i));
            chk($sformatf("d5.drain%0d.count", i), 32'(d_cnt), 32'(1 - i));
        end
        chk("d5.empty", 32'(d_empty), 32'd1);
        chk("d5.overflow", 32'(d_ovf), 32'd0);
        chk("d5.underflow", 32'(d_unf), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step_d5(1, 8'(8'h80 + i), 0);
            chk($sformatf("d5.fill%0d.count", i), 32'(d_cnt), 32'(i + 1));
            chk($sformatf("d5.fill%0d.full", i), 32'(d_full), 32'(i == 4));
            chk($sformatf("d5.fill%0d.af", i), 32'(d_af), 32'(i + 1 >= 4));
        end
        step_d5(0, 8'h00, 1);
        chk("d5.wrapped_head", 32'(d_rdata), 32'h80);

        // ---- FWFT ----
        chk("fw.reset_empty", 32'(f_empty), 32'd1);
        chk("fw.reset_rv", 32'(f_rv), 32'd0);
        chk("fw.reset_rdata", 32'(f_rdata), 32'd0);
        step_fw(0, 1, 8'h3C, 0);
        chk("fw.w1_rdata", 32'(f_rdata), 32'h3C);
        chk("fw.w1_rv", 32'(f_rv), 32'd1);
        chk("fw.w1_count", 32'(f_cnt), 32'd1);
        step_fw(0, 1, 8'h3D, 0);
        chk("fw.w2_head", 32'(f_rdata), 32'h3C);
        step_fw(0, 0, 8'h00, 1);
        chk("fw.pop_rdata", 32'(f_rdata), 32'h3D);
        chk("fw.pop_count", 32'(f_cnt), 32'd1);
        step_fw(0, 1, 8'h3E, 0);
        step_fw(0, 1, 8'h3F, 0);
        chk("fw.burst_count", 32'(f_cnt), 32'd3);
        step_fw(1, 1, 8'h40, 1);
        chk("fw.res_empty", 32'(f_empty), 32'd1);
        chk("fw.res_count", 32'(f_cnt), 32'd0);
        chk("fw.res_rv", 32'(f_rv), 32'd0);
        step_fw(0, 1, 8'h77, 0);
        chk("fw.after_res_rdata", 32'(f_rdata), 32'h77);
        chk("fw.after_res_rv", 32'(f_rv), 32'd1);
        step_fw(0, 0, 8'h00, 1);
        chk("fw.final_empty", 32'(f_empty), 32'd1);
        chk("fw.final_rv", 32'(f_rv), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
